// File: rtl/div_issue_ctrl_pkg.sv
// div_issue_ctrl_pkg: shared types for the DIV issue path.
// State encoding, divider handshake levels, bus widths.
package div_issue_ctrl_pkg;

  localparam int RegBusW       = 32;
  localparam int DoubleRegBusW = 64;

  typedef logic [RegBusW-1:0]       reg_bus_t;
  typedef logic [DoubleRegBusW-1:0] dreg_bus_t;

  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;
  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;

  localparam reg_bus_t ZeroWord = '0;

  typedef enum logic [2:0] {
    DIVC_IDLE,
    DIVC_BUSY,
    DIVC_DONE,
    DIVC_DRAIN,
    DIVC_DROP
  } divc_state_e;

  function automatic logic wdog_active(
    input divc_state_e s
  );
    return (s == DIVC_BUSY) || (s == DIVC_DRAIN);
  endfunction

endpackage

// File: rtl/div_issue_ctrl_if.sv
// div_issue_ctrl_if: controller <-> radix-4 divider bundle.
// The divider has no abort; div_start doubles as DivStop.
interface div_issue_ctrl_if;
  import div_issue_ctrl_pkg::*;

  logic      div_start;
  logic      signed_div_o;
  reg_bus_t  div_opdata1;
  reg_bus_t  div_opdata2;
  dreg_bus_t div_result;
  logic      div_ready;

  modport master (
    output div_start,
    output signed_div_o,
    output div_opdata1,
    output div_opdata2,
    input  div_result,
    input  div_ready
  );

  modport slave (
    input  div_start,
    input  signed_div_o,
    input  div_opdata1,
    input  div_opdata2,
    output div_result,
    output div_ready
  );

endinterface

// File: rtl/div_issue_ctrl.sv
// div_issue_ctrl: EX-stage sequencer for DIV/DIVU.
// Holds div_start across a divide; drains on flush.
module div_issue_ctrl
  import div_issue_ctrl_pkg::*;
#(
  parameter int WDOG_MAX = 63,
  parameter int WDOG_W   = 6
) (
  input  logic             cpu_clk_75M,
  input  logic             cpu_rst,
  input  logic             ex_div_req,
  input  logic             ex_div_signed,
  input  reg_bus_t         ex_opdata1,
  input  reg_bus_t         ex_opdata2,
  input  logic             flush,
  div_issue_ctrl_if.master div_bus,
  output logic             stallreq_div,
  output logic             hilo_we,
  output reg_bus_t         hi_o,
  output reg_bus_t         lo_o,
  output logic             div_timeout
);

  localparam logic [WDOG_W-1:0] WDOG_LIM =
    WDOG_W'(WDOG_MAX);

  divc_state_e       state;
  logic [WDOG_W-1:0] wdog;
  logic              wdog_on;
  logic              rdy;

  assign wdog_on = wdog_active(state);
  assign rdy     = (div_bus.div_ready == DivResultReady);

  // Sequence one divide: start, wait, write or discard.
  always_ff @(posedge cpu_clk_75M) begin
    if (cpu_rst) begin
      state                <= DIVC_IDLE;
      div_bus.div_start    <= DivStop;
      div_bus.signed_div_o <= 1'b0;
      div_bus.div_opdata1  <= ZeroWord;
      div_bus.div_opdata2  <= ZeroWord;
      hi_o                 <= ZeroWord;
      lo_o                 <= ZeroWord;
    end else begin
      unique case (state)
        DIVC_IDLE: begin
          if (ex_div_req && !flush) begin
            div_bus.div_opdata1  <= ex_opdata1;
            div_bus.div_opdata2  <= ex_opdata2;
            div_bus.signed_div_o <= ex_div_signed;
            div_bus.div_start    <= DivStart;
            state                <= DIVC_BUSY;
          end
        end
        DIVC_BUSY: begin
          if (rdy) begin
            div_bus.div_start <= DivStop;
            if (flush) begin
              state <= DIVC_DROP;
            end else begin
              hi_o  <= div_bus.div_result[63:32];
              lo_o  <= div_bus.div_result[31:0];
              state <= DIVC_DONE;
            end
          end else if (flush) begin
            state <= DIVC_DRAIN;
          end
        end
        DIVC_DRAIN: begin
          if (rdy) begin
            div_bus.div_start <= DivStop;
            state             <= DIVC_DROP;
          end
        end
        DIVC_DONE: state <= DIVC_IDLE;
        DIVC_DROP: state <= DIVC_IDLE;
        default:   state <= DIVC_IDLE;
      endcase
    end
  end

  // Stall and HI/LO strobe depend on live request/flush.
  always_comb begin
    stallreq_div = 1'b0;
    hilo_we      = 1'b0;
    unique case (state)
      DIVC_IDLE: stallreq_div = ex_div_req & ~flush;
      DIVC_BUSY: stallreq_div = 1'b1;
      DIVC_DONE: hilo_we      = ~flush;
      DIVC_DROP: stallreq_div = ex_div_req;
      default:   stallreq_div = 1'b0;
    endcase
  end

  // Count busy/drain cycles; sticky timeout at the limit.
  always_ff @(posedge cpu_clk_75M) begin
    if (cpu_rst) begin
      wdog        <= '0;
      div_timeout <= 1'b0;
    end else if (wdog_on) begin
      if (wdog != WDOG_LIM)
        wdog <= wdog + WDOG_W'(1);
      if (wdog >= WDOG_LIM - WDOG_W'(1))
        div_timeout <= 1'b1;
    end else begin
      wdog <= '0;
    end
  end

endmodule

// File: tb/tb_div_issue_ctrl.sv
// tb_div_issue_ctrl: vector table, hand sequences, random ops.
// A behavioural divider stub answers the controller.
module tb_div_issue_ctrl;
  import div_issue_ctrl_pkg::*;

  logic        cpu_clk_75M = 1'b0;
  logic        cpu_rst = 1'b1;
  logic        ex_div_req = 1'b0;
  logic        ex_div_signed = 1'b0;
  logic [31:0] ex_opdata1 = '0;
  logic [31:0] ex_opdata2 = '0;
  logic        flush = 1'b0;
  logic        stallreq_div;
  logic        hilo_we;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic        div_timeout;

  div_issue_ctrl_if dif();

  div_issue_ctrl #(
    .WDOG_MAX(63),
    .WDOG_W(6)
  ) dut (
    .cpu_clk_75M(cpu_clk_75M),
    .cpu_rst(cpu_rst),
    .ex_div_req(ex_div_req),
    .ex_div_signed(ex_div_signed),
    .ex_opdata1(ex_opdata1),
    .ex_opdata2(ex_opdata2),
    .flush(flush),
    .div_bus(dif),
    .stallreq_div(stallreq_div),
    .hilo_we(hilo_we),
    .hi_o(hi_o),
    .lo_o(lo_o),
    .div_timeout(div_timeout)
  );

  always #5 cpu_clk_75M = ~cpu_clk_75M;

  int n_cmp = 0;
  int n_bad = 0;

  // MIPS DIV/DIVU: {rem, quot}; divide by zero yields 0/0.
  function automatic logic [63:0] ref_div(
    input logic s,
    input logic [31:0] a,
    input logic [31:0] b
  );
    int sa;
    int sb;
    if (b == 32'd0) return 64'd0;
    if (s) begin
      sa = a;
      sb = b;
      return {32'(sa % sb), 32'(sa / sb)};
    end
    return {a % b, a / b};
  endfunction

  task automatic chk(
    input string nm,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h",
               nm, got, exp);
    end
  endtask

  task automatic step;
    @(posedge cpu_clk_75M);
    #1;
  endtask

  // Divider stub: latency, then holds ready while start stays high.
  int stub_lat = 0;
  bit stub_stuck = 1'b0;
  int sst;
  int scnt;

  always @(posedge cpu_clk_75M) begin
    if (cpu_rst) begin
      sst            <= 0;
      scnt           <= 0;
      dif.div_ready  <= 1'b0;
      dif.div_result <= '0;
    end else begin
      case (sst)
        0: if (dif.div_start) begin
          sst  <= 1;
          scnt <= (stub_lat > 0) ? stub_lat :
                  ((dif.div_opdata2 == 0) ? 3 : 19);
        end
        1: if (!stub_stuck) begin
          if (scnt <= 1) begin
            sst            <= 2;
            dif.div_ready  <= 1'b1;
            dif.div_result <= ref_div(dif.signed_div_o,
                                      dif.div_opdata1,
                                      dif.div_opdata2);
          end else begin
            scnt <= scnt - 1;
          end
        end
        default: if (!dif.div_start) begin
          sst            <= 0;
          dif.div_ready  <= 1'b0;
          dif.div_result <= '0;
        end
      endcase
    end
  end

  // Present one DIV; hold it until written or flushed.
  task automatic issue(
    input  logic        s,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  int          fat,
    input  bit          seq,
    output int          wes,
    output logic [31:0] h,
    output logic [31:0] l,
    output int          cyc,
    output bit          fl
  );
    int  n;
    int  nostall;
    bit  done;
    wes = 0; h = '0; l = '0; cyc = 0; fl = 1'b0;
    n = 0; nostall = 0; done = 1'b0;
    ex_div_req    = 1'b1;
    ex_div_signed = s;
    ex_opdata1    = a;
    ex_opdata2    = b;
    while (!done) begin
      flush = (n == fat);
      #1;
      if (seq && n == 0)
        chk("start_low_at_req", dif.div_start, 0);
      if (seq && n == 1)
        chk("start_rise", dif.div_start, 1);
      if (hilo_we) begin
        wes++;
        h = hi_o;
        l = lo_o;
        done = 1'b1;
        chk("start_fall_done", dif.div_start, 0);
      end else if (flush) begin
        fl = 1'b1;
        done = 1'b1;
      end else if (!stallreq_div) begin
        nostall++;
      end
      if (!done && n >= 300) begin
        chk("issue_bound", n, 0);
        done = 1'b1;
      end
      cyc = n;
      @(posedge cpu_clk_75M);
      #1;
      n++;
    end
    ex_div_req = 1'b0;
    flush      = 1'b0;
    if (seq && !fl)
      chk("stall_held", nostall, 0);
  endtask

  // Idle cycles until the divider has been released.
  task automatic drain(output int wes);
    bit fin;
    wes = 0;
    fin = 1'b0;
    for (int k = 0; k < 80 && !fin; k++) begin
      #1;
      if (hilo_we) wes++;
      if (!dif.div_start) fin = 1'b1;
      step();
    end
    if (!fin) chk("drain_bound", 1, 0);
  endtask

  typedef struct {
    logic        s;
    logic [31:0] a;
    logic [31:0] b;
    int          fat;
    int          gap;
    bit          seq;
    logic [31:0] hi;
    logic [31:0] lo;
    int          maxc;
  } vec_t;

  vec_t tbl[10];

  int          wes;
  int          cyc;
  int          wd;
  bit          fl;
  logic [31:0] h;
  logic [31:0] l;
  logic        rs;
  logic [31:0] ra;
  logic [31:0] rb;
  int          rf;
  logic [63:0] ex;

  initial begin
    tbl[0] = '{1'b0, 32'd100, 32'd7, -1, 0, 1'b1,
               32'd2, 32'd14, 25};
    tbl[1] = '{1'b1, 32'hFFFF_FFF9, 32'd2, -1, 0, 1'b1,
               32'hFFFF_FFFF, 32'hFFFF_FFFD, 25};
    tbl[2] = '{1'b0, 32'd1000, 32'd3, 5, 0, 1'b1,
               32'hFFFF_FFFF, 32'hFFFF_FFFD, 25};
    tbl[3] = '{1'b0, 32'd1000, 32'd3, -1, 0, 1'b0,
               32'd1, 32'h14D, 60};
    tbl[4] = '{1'b0, 32'd77, 32'd7, 0, 2, 1'b0,
               32'd1, 32'h14D, 5};
    tbl[5] = '{1'b1, 32'd7, 32'hFFFF_FFFE, -1, 0, 1'b1,
               32'd1, 32'hFFFF_FFFD, 25};
    tbl[6] = '{1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, -1, 0,
               1'b1, 32'hFFFF_FFFE, 32'hE, 25};
    tbl[7] = '{1'b0, 32'h1234_5678, 32'd0, -1, 0, 1'b1,
               32'd0, 32'd0, 6};
    tbl[8] = '{1'b0, 32'd50, 32'd5, -1, 3, 1'b1,
               32'd0, 32'd10, 25};
    tbl[9] = '{1'b0, 32'd9, 32'd4, -1, 0, 1'b1,
               32'd1, 32'd2, 25};

    repeat (3) @(posedge cpu_clk_75M);
    #2;
    chk("rst_start", dif.div_start, 0);
    chk("rst_signed", dif.signed_div_o, 0);
    chk("rst_op1", dif.div_opdata1, 0);
    chk("rst_op2", dif.div_opdata2, 0);
    chk("rst_stall", stallreq_div, 0);
    chk("rst_we", hilo_we, 0);
    chk("rst_hilo", {hi_o, lo_o}, 0);
    chk("rst_tmo", div_timeout, 0);
    cpu_rst = 1'b0;
    step();

    for (int i = 0; i < 10; i++) begin
      repeat (tbl[i].gap) step();
      issue(tbl[i].s, tbl[i].a, tbl[i].b, tbl[i].fat,
            tbl[i].seq, wes, h, l, cyc, fl);
      if (tbl[i].fat >= 0) begin
        chk("vec_flushed", fl, 1);
        #1;
        chk("flush_start_kept", dif.div_start,
            tbl[i].fat > 0);
        chk("flush_no_stall", stallreq_div, 0);
        chk("flush_no_we", hilo_we, 0);
        chk("flush_hi_kept", hi_o, tbl[i].hi);
        chk("flush_lo_kept", lo_o, tbl[i].lo);
        step();
      end else begin
        chk("vec_we_once", wes, 1);
        chk("vec_hi", h, tbl[i].hi);
        chk("vec_lo", l, tbl[i].lo);
        chk("vec_latency", cyc <= tbl[i].maxc, 1);
      end
    end

    // Reset in the middle of a divide.
    ex_div_req    = 1'b1;
    ex_div_signed = 1'b1;
    ex_opdata1    = 32'hFFFF_FFF9;
    ex_opdata2    = 32'd3;
    repeat (4) step();
    chk("mid_busy_stall", stallreq_div, 1);
    cpu_rst    = 1'b1;
    ex_div_req = 1'b0;
    step();
    cpu_rst = 1'b0;
    #1;
    chk("mrst_start", dif.div_start, 0);
    chk("mrst_signed", dif.signed_div_o, 0);
    chk("mrst_ops", {dif.div_opdata1, dif.div_opdata2}, 0);
    chk("mrst_stall", stallreq_div, 0);
    chk("mrst_we", hilo_we, 0);
    chk("mrst_hilo", {hi_o, lo_o}, 0);
    step();
    issue(1'b0, 32'd100, 32'd7, -1, 1'b1, wes, h, l, cyc, fl);
    chk("post_rst_we", wes, 1);
    chk("post_rst_hilo", {h, l}, {32'd2, 32'd14});

    // Divider that never answers trips the watchdog.
    stub_stuck    = 1'b1;
    ex_div_req    = 1'b1;
    ex_div_signed = 1'b0;
    ex_opdata1    = 32'd5;
    ex_opdata2    = 32'd1;
    #1;
    chk("wd_req_stall", stallreq_div, 1);
    step();
    repeat (62) step();
    chk("wd_not_yet", div_timeout, 0);
    step();
    chk("wd_raised", div_timeout, 1);
    repeat (5) step();
    chk("wd_sticky", div_timeout, 1);
    chk("wd_still_stall", stallreq_div, 1);
    chk("wd_still_start", dif.div_start, 1);
    cpu_rst    = 1'b1;
    ex_div_req = 1'b0;
    step();
    cpu_rst    = 1'b0;
    stub_stuck = 1'b0;
    #1;
    chk("wd_cleared", div_timeout, 0);
    step();

    // Random operations against the arithmetic reference.
    for (int i = 0; i < 40; i++) begin
      stub_lat = $urandom_range(1, 24);
      rs = 1'($urandom_range(0, 1));
      ra = $urandom;
      case ($urandom_range(0, 4))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 9));
        2: rb = 32'hFFFF_FFFF - 32'($urandom_range(0, 8));
        default: rb = $urandom;
      endcase
      if (rs && ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF)
        rb = 32'd1;
      rf = ($urandom_range(0, 3) == 0) ?
           int'($urandom_range(0, stub_lat + 4)) : -1;
      ex = ref_div(rs, ra, rb);
      issue(rs, ra, rb, rf, rf != 0, wes, h, l, cyc, fl);
      if (fl) begin
        chk("rnd_flush_we", wes, 0);
        drain(wd);
        chk("rnd_drain_we", wd, 0);
      end else begin
        chk("rnd_we_once", wes, 1);
        chk("rnd_hilo", {h, l}, ex);
        chk("rnd_latency", cyc <= stub_lat + 3, 1);
      end
      if (($urandom_range(0, 1)) == 1) step();
    end
    chk("rnd_no_tmo", div_timeout, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
